// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer for the core front end
// One outstanding imem request at a time, with redirect, stale-response drain and fault reporting.
module fetch_sequencer #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            start,
  input  logic [XLEN-1:0] pc_addr,
  input  logic            pc_ovf,
  output logic            pc_enable,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_loaded,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            imem_err,
  input  logic [31:0]     imem_rdata,
  input  logic            branch_req,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vector,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            fault,
  output logic [1:0]      fault_cause
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_HOLD, S_DRAIN, S_FAULT
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic [31:0]     instr_data_q;
  logic [TW-1:0]   tmo_q;
  logic [1:0]      cause_q;

  logic            live;
  logic            redir;
  logic            resp;
  logic            tmo_hit;
  logic            in_flight;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] drain_pc_d;

  assign live       = clk_en && !rst;
  assign redir      = trap_req || branch_req;
  assign redir_tgt  = trap_req ? trap_vector : branch_target;
  assign resp       = imem_ack || imem_err;
  assign tmo_hit    = (tmo_q == TMO_LAST);
  assign in_flight  = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign drain_pc_d = redir ? redir_tgt : req_pc_q;

  // A redirect always suppresses pc_enable, so the two pulses are mutually exclusive.
  assign pc_load   = live && ((redir && (in_flight || state_q == S_HOLD)) ||
                              (trap_req && state_q == S_FAULT));
  assign pc_enable = live && (state_q == S_WAIT) && imem_ack && !redir;
  assign pc_loaded = pc_load ? redir_tgt : '0;

  assign imem_req    = in_flight;
  assign imem_addr   = in_flight ? addr_q : '0;
  assign instr_valid = (state_q == S_HOLD) && !pc_load;
  assign instr_data  = instr_data_q;
  assign instr_pc    = instr_pc_q;
  assign fault       = (state_q == S_FAULT);
  assign fault_cause = fault ? cause_q : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_pc_q     <= '0;
      addr_q       <= '0;
      instr_pc_q   <= '0;
      instr_data_q <= '0;
      tmo_q        <= '0;
      cause_q      <= 2'b00;
    end else if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_WAIT;
            req_pc_q <= pc_addr;
            addr_q   <= pc_addr;
            tmo_q    <= '0;
          end
        end
        S_WAIT: begin
          if (redir) begin
            req_pc_q <= redir_tgt;
            tmo_q    <= '0;
            if (resp) begin
              state_q <= S_WAIT;
              addr_q  <= redir_tgt;
            end else begin
              state_q <= S_DRAIN;
            end
          end else if (imem_ack) begin
            instr_data_q <= imem_rdata;
            instr_pc_q   <= req_pc_q;
            state_q      <= S_HOLD;
          end else if (imem_err) begin
            cause_q <= 2'b10;
            state_q <= S_FAULT;
          end else if (tmo_hit) begin
            cause_q <= 2'b11;
            state_q <= S_FAULT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_HOLD: begin
          if (redir) begin
            req_pc_q <= redir_tgt;
            addr_q   <= redir_tgt;
            tmo_q    <= '0;
            state_q  <= S_WAIT;
          end else if (instr_ready) begin
            if (pc_ovf) begin
              cause_q <= 2'b01;
              state_q <= S_FAULT;
            end else begin
              req_pc_q <= pc_addr;
              addr_q   <= pc_addr;
              tmo_q    <= '0;
              state_q  <= S_WAIT;
            end
          end
        end
        S_DRAIN: begin
          // The response here belongs to the abandoned address; it only ends the drain.
          req_pc_q <= drain_pc_d;
          if (resp) begin
            addr_q  <= drain_pc_d;
            tmo_q   <= '0;
            state_q <= S_WAIT;
          end else if (tmo_hit) begin
            cause_q <= 2'b11;
            state_q <= S_FAULT;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_FAULT: begin
          if (trap_req) begin
            req_pc_q <= trap_vector;
            addr_q   <= trap_vector;
            tmo_q    <= '0;
            cause_q  <= 2'b00;
            state_q  <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
// Directed vector table, hand-written fault/reset sequences, then randomized run against a stream model.
module tb_fetch_sequencer;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
  localparam int NRAND   = 3000;

  logic            clk = 1'b0;
  logic            rst, clk_en, start, pc_ovf;
  logic [XLEN-1:0] pc_addr;
  logic            pc_enable, pc_load;
  logic [XLEN-1:0] pc_loaded;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack, imem_err;
  logic [31:0]     imem_rdata;
  logic            branch_req, trap_req;
  logic [XLEN-1:0] branch_target, trap_vector;
  logic            instr_valid, instr_ready;
  logic [31:0]     instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            fault;
  logic [1:0]      fault_cause;

  int checks = 0;
  int failures = 0;

  fetch_sequencer #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
    .pc_addr(pc_addr), .pc_ovf(pc_ovf),
    .pc_enable(pc_enable), .pc_load(pc_load), .pc_loaded(pc_loaded),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .branch_req(branch_req), .branch_target(branch_target),
    .trap_req(trap_req), .trap_vector(trap_vector),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  // Program counter as seen by the sequencer.
  always @(posedge clk) begin
    if (rst) pc_addr <= '0;
    else if (pc_load) pc_addr <= pc_loaded;
    else if (pc_enable) pc_addr <= pc_addr + 32'd4;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = 0; imem_ack = 0; imem_err = 0; instr_ready = 0;
    branch_req = 0; trap_req = 0; clk_en = 1; pc_ovf = 0;
  endtask

  typedef struct {
    logic        start, ack, ready, br, tr, ce;
    logic [31:0] rdata, bt, tv;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc, idata;
    logic        pce, pcl;
    logic [31:0] loaded;
  } vec_t;

  vec_t tbl[24];

  logic        holding, stale, redir, exp_pce;
  logic [31:0] exp_pc, tgt;
  int          wcnt;

  initial begin
    rst = 1; clk_en = 1; start = 0; pc_ovf = 0;
    imem_ack = 0; imem_err = 0; imem_rdata = 0; instr_ready = 0;
    branch_req = 0; trap_req = 0; branch_target = 0; trap_vector = 0;

    //            st ak rd br tr ce rdata      bt      tv     | req addr    vld ipc     idata  pce pcl loaded
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 32'h0,     32'h0,  32'h0,   0, 32'h0,   0, 32'h0,   32'h0,  0, 0, 32'h0};
    tbl[1]  = '{0, 1, 0, 0, 0, 1, 32'h11,    32'h0,  32'h0,   1, 32'h0,   0, 32'h0,   32'h0,  1, 0, 32'h0};
    tbl[2]  = '{0, 0, 1, 0, 0, 1, 32'h0,     32'h0,  32'h0,   0, 32'h0,   1, 32'h0,   32'h11, 0, 0, 32'h0};
    tbl[3]  = '{0, 1, 0, 0, 0, 1, 32'h22,    32'h0,  32'h0,   1, 32'h4,   0, 32'h0,   32'h11, 1, 0, 32'h0};
    tbl[4]  = '{0, 0, 1, 0, 0, 1, 32'h0,     32'h0,  32'h0,   0, 32'h0,   1, 32'h4,   32'h22, 0, 0, 32'h0};
    tbl[5]  = '{0, 1, 0, 0, 0, 1, 32'h13,    32'h0,  32'h0,   1, 32'h8,   0, 32'h4,   32'h22, 1, 0, 32'h0};
    for (int i = 6; i <= 10; i++)
      tbl[i] = '{0, 0, 0, 0, 0, 1, 32'h0,    32'h0,  32'h0,   0, 32'h0,   1, 32'h8,   32'h13, 0, 0, 32'h0};
    tbl[11] = '{0, 0, 1, 0, 0, 1, 32'h0,     32'h0,  32'h0,   0, 32'h0,   1, 32'h8,   32'h13, 0, 0, 32'h0};
    tbl[12] = '{0, 0, 0, 0, 0, 1, 32'h0,     32'h0,  32'h0,   1, 32'hC,   0, 32'h8,   32'h13, 0, 0, 32'h0};
    tbl[13] = '{0, 0, 0, 1, 0, 1, 32'h0,     32'h100,32'h0,   1, 32'hC,   0, 32'h8,   32'h13, 0, 1, 32'h100};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 32'h0,     32'h0,  32'h0,   1, 32'hC,   0, 32'h8,   32'h13, 0, 0, 32'h0};
    tbl[15] = '{0, 0, 0, 0, 0, 1, 32'h0,     32'h0,  32'h0,   1, 32'hC,   0, 32'h8,   32'h13, 0, 0, 32'h0};
    tbl[16] = '{0, 1, 0, 0, 0, 1, 32'hDEAD,  32'h0,  32'h0,   1, 32'hC,   0, 32'h8,   32'h13, 0, 0, 32'h0};
    tbl[17] = '{0, 0, 0, 0, 0, 1, 32'h0,     32'h0,  32'h0,   1, 32'h100, 0, 32'h8,   32'h13, 0, 0, 32'h0};
    tbl[18] = '{0, 1, 0, 1, 1, 1, 32'h33,    32'h300,32'h200, 1, 32'h100, 0, 32'h8,   32'h13, 0, 1, 32'h200};
    tbl[19] = '{0, 1, 0, 0, 0, 1, 32'h44,    32'h0,  32'h0,   1, 32'h200, 0, 32'h8,   32'h13, 1, 0, 32'h0};
    tbl[20] = '{0, 0, 1, 1, 0, 1, 32'h0,     32'h80, 32'h0,   0, 32'h0,   0, 32'h200, 32'h44, 0, 1, 32'h80};
    tbl[21] = '{0, 1, 0, 0, 0, 0, 32'h55,    32'h0,  32'h0,   1, 32'h80,  0, 32'h200, 32'h44, 0, 0, 32'h0};
    tbl[22] = '{0, 1, 0, 0, 0, 1, 32'h55,    32'h0,  32'h0,   1, 32'h80,  0, 32'h200, 32'h44, 1, 0, 32'h0};
    tbl[23] = '{0, 0, 1, 0, 0, 1, 32'h0,     32'h0,  32'h0,   0, 32'h0,   1, 32'h80,  32'h55, 0, 0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pce", pc_enable, 0);     chk("rst_pcl", pc_load, 0);
    chk("rst_loaded", pc_loaded, 0);  chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);    chk("rst_valid", instr_valid, 0);
    chk("rst_data", instr_data, 0);   chk("rst_ipc", instr_pc, 0);
    chk("rst_fault", fault, 0);       chk("rst_cause", fault_cause, 0);
    rst = 0;

    for (int i = 0; i < 24; i++) begin
      start = tbl[i].start; imem_ack = tbl[i].ack; instr_ready = tbl[i].ready;
      branch_req = tbl[i].br; trap_req = tbl[i].tr; clk_en = tbl[i].ce;
      imem_rdata = tbl[i].rdata; branch_target = tbl[i].bt; trap_vector = tbl[i].tv;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), imem_req, tbl[i].req);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), instr_valid, tbl[i].valid);
      chk($sformatf("v%0d_ipc", i), instr_pc, tbl[i].ipc);
      chk($sformatf("v%0d_data", i), instr_data, tbl[i].idata);
      chk($sformatf("v%0d_pce", i), pc_enable, tbl[i].pce);
      chk($sformatf("v%0d_pcl", i), pc_load, tbl[i].pcl);
      chk($sformatf("v%0d_loaded", i), pc_loaded, tbl[i].loaded);
      chk($sformatf("v%0d_fault", i), fault, 0);
      tick();
    end

    // Timeout: TIMEOUT silent WAIT cycles, then fault with cause 11.
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      chk($sformatf("tmo_wait%0d_fault", i), fault, 0);
      chk($sformatf("tmo_wait%0d_addr", i), imem_addr, 32'h84);
      tick();
    end
    branch_req = 1; branch_target = 32'h500;
    @(negedge clk);
    chk("tmo_fault", fault, 1);       chk("tmo_cause", fault_cause, 2'b11);
    chk("tmo_req", imem_req, 0);      chk("fault_branch_ignored", pc_load, 0);
    tick();
    chk("fault_held", fault, 1);
    trap_req = 1; trap_vector = 32'h200; branch_req = 1; branch_target = 32'h500;
    @(negedge clk);
    chk("trap_pcl", pc_load, 1);      chk("trap_loaded", pc_loaded, 32'h200);
    tick();
    imem_ack = 1; imem_rdata = 32'h66;
    @(negedge clk);
    chk("trap_fault_clr", fault, 0);  chk("trap_cause_clr", fault_cause, 0);
    chk("trap_addr", imem_addr, 32'h200); chk("trap_ack_pce", pc_enable, 1);
    tick();
    instr_ready = 1; pc_ovf = 1;
    @(negedge clk);
    chk("ovf_valid", instr_valid, 1); chk("ovf_ipc", instr_pc, 32'h200);
    chk("ovf_data", instr_data, 32'h66);
    tick();
    trap_req = 1; trap_vector = 32'h300;
    @(negedge clk);
    chk("ovf_fault", fault, 1);       chk("ovf_cause", fault_cause, 2'b01);
    chk("ovf_req", imem_req, 0);
    tick();
    imem_err = 1;
    @(negedge clk);
    chk("err_addr", imem_addr, 32'h300); chk("err_pce", pc_enable, 0);
    tick();
    trap_req = 1; trap_vector = 32'h400;
    @(negedge clk);
    chk("err_fault", fault, 1);       chk("err_cause", fault_cause, 2'b10);
    tick();
    @(negedge clk);
    chk("pre_rst_addr", imem_addr, 32'h400);
    tick();
    rst = 1; imem_ack = 1; imem_rdata = 32'h77;
    tick();
    rst = 0; imem_ack = 1; imem_rdata = 32'h77;
    @(negedge clk);
    chk("mid_rst_req", imem_req, 0);  chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_valid", instr_valid, 0); chk("mid_rst_pce", pc_enable, 0);
    chk("mid_rst_ipc", instr_pc, 0);  chk("mid_rst_data", instr_data, 0);
    chk("mid_rst_fault", fault, 0);   chk("mid_rst_cause", fault_cause, 0);
    tick();
    @(negedge clk);
    chk("post_rst_idle_req", imem_req, 0);
    chk("post_rst_idle_valid", instr_valid, 0);
    tick();

    // Randomized run: the model tracks only which instruction address must appear next.
    start = 1;
    @(negedge clk);
    tick();
    holding = 0; stale = 0; exp_pc = 32'h0; wcnt = 0;
    for (int c = 0; c < NRAND; c++) begin
      int r;
      clk_en = ($urandom % 10) != 0;
      imem_ack = imem_req && (wcnt >= 4 || ($urandom % 2) == 1);
      imem_rdata = mem_word(imem_addr);
      instr_ready = ($urandom % 10) < 6;
      r = $urandom % 100;
      branch_req = r < 6;
      trap_req = r >= 3 && r < 9;
      branch_target = {22'h0, 8'($urandom), 2'b00};
      trap_vector = {20'h0, 10'($urandom), 2'b00};
      @(negedge clk);
      chk("r_req", imem_req, !holding);
      if (clk_en) begin
        redir = branch_req || trap_req;
        tgt = trap_req ? trap_vector : branch_target;
        exp_pce = !redir && !holding && imem_ack && !stale;
        chk("r_pcl", pc_load, redir);
        if (redir) chk("r_loaded", pc_loaded, tgt);
        chk("r_valid", instr_valid, holding && !redir);
        chk("r_pce", pc_enable, exp_pce);
        if (redir) begin
          if (!holding) stale = !imem_ack;
          holding = 0;
          exp_pc = tgt;
        end else if (holding) begin
          if (instr_ready) begin
            chk("r_ipc", instr_pc, exp_pc);
            chk("r_data", instr_data, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            holding = 0;
          end
        end else if (imem_ack) begin
          if (stale) stale = 0;
          else begin
            chk("r_addr", imem_addr, exp_pc);
            holding = 1;
          end
        end
        if (imem_ack) wcnt = 0;
        else if (imem_req) wcnt++;
      end else begin
        chk("r_ce0_pce", pc_enable, 0);
        chk("r_ce0_pcl", pc_load, 0);
      end
      chk("r_nofault", fault, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
